// File: rtl/nand2tetris_pkg.sv
// Shared constants and entry-state encoding for the Hack-word routing blocks.
package nand2tetris_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int DROP_CNT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } entry_state_e;

endpackage : nand2tetris_pkg

// File: rtl/dmux_nway_gate.sv
// Combinational 1-to-N demultiplexer: routes a single bit onto the selected channel,
// all-zero output when the select addresses a channel that does not exist.
module dmux_nway_gate #(
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                din_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [CHANNELS-1:0] dout_o
);

    always_comb begin
        // NOTE: default first so every path assigns dout_o; otherwise a latch is inferred.
        dout_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_i == SEL_W'(k)) begin
                dout_o[k] = din_i;
            end
        end
    end

endmodule : dmux_nway_gate

// File: rtl/dmux_nway_reg.sv
// One-entry registered N-way demultiplexer with valid/ready on every channel.
// Optional saturating drop counter for out-of-range selects: DMUX_NWAY_DROP_CNT_EN.
module dmux_nway_reg
    import nand2tetris_pkg::*;
#(
    parameter int  WIDTH    = HACK_WORD_W,
    parameter int  CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready
`ifdef DMUX_NWAY_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_count
`endif
);

    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

    entry_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SEL_W-1:0] sel_q,   sel_d;

    logic [CHANNELS-1:0] lane_en;
    logic                drain;
    logic                accept;
    logic                in_range;

    dmux_nway_gate #(
        .CHANNELS (CHANNELS)
    ) u_gate (
        .din_i  (state_q == FULL),
        .sel_i  (sel_q),
        .dout_o (lane_en)
    );

    // Only the held channel's ready can drain the entry; others are masked off here.
    assign drain    = |(lane_en & out_ready);
    assign in_ready = !reset && ((state_q == EMPTY) || drain);
    assign accept   = in_valid && in_ready;
    assign in_range = {1'b0, in_sel} < CH_LIM;

    assign out_valid = lane_en;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign out_data[k*WIDTH +: WIDTH] = lane_en[k] ? data_q : '0;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (drain) begin
            state_d = EMPTY;
        end
        if (accept && in_range) begin
            state_d = FULL;
            data_d  = in_data;
            sel_d   = in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all sequential state avoid simulation races.
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

`ifdef DMUX_NWAY_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (accept && !in_range && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule : dmux_nway_reg

// File: tb/tb_dmux_nway_reg.sv
// Randomised and directed bench for dmux_nway_reg: an 8-channel and a 6-channel instance
// checked every cycle against a behavioural one-entry model.
module tb_dmux_nway_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus (index 0: 8 channels, index 1: 6 channels)
    logic        cur_rst [2];
    logic        cur_vld [2];
    logic [15:0] cur_dat [2];
    logic [2:0]  cur_sel [2];
    logic [7:0]  cur_rdy [2];

    // Reference model state
    bit          m_full  [2];
    int          m_sel   [2];
    logic [15:0] m_data  [2];
    int          m_drops [2];
    int          nch     [2];

    int n_checks = 0;
    int n_errors = 0;

    logic         ir0, ir1;
    logic [7:0]   ov0;
    logic [5:0]   ov1;
    logic [127:0] od0;
    logic [95:0]  od1;
`ifdef DMUX_NWAY_DROP_CNT_EN
    logic [7:0]   dc0, dc1;
`endif

    dmux_nway_reg #(.WIDTH(16), .CHANNELS(8)) u_dut8 (
        .clk       (clk),
        .reset     (cur_rst[0]),
        .in_data   (cur_dat[0]),
        .in_sel    (cur_sel[0]),
        .in_valid  (cur_vld[0]),
        .in_ready  (ir0),
        .out_data  (od0),
        .out_valid (ov0),
        .out_ready (cur_rdy[0])
`ifdef DMUX_NWAY_DROP_CNT_EN
        ,
        .drop_count(dc0)
`endif
    );

    dmux_nway_reg #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
        .clk       (clk),
        .reset     (cur_rst[1]),
        .in_data   (cur_dat[1]),
        .in_sel    (cur_sel[1]),
        .in_valid  (cur_vld[1]),
        .in_ready  (ir1),
        .out_data  (od1),
        .out_valid (ov1),
        .out_ready (cur_rdy[1][5:0])
`ifdef DMUX_NWAY_DROP_CNT_EN
        ,
        .drop_count(dc1)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] exp_valid(int d);
        return m_full[d] ? (128'(1) << m_sel[d]) : 128'(0);
    endfunction

    function automatic logic [127:0] exp_data(int d);
        return m_full[d] ? (128'(m_data[d]) << (m_sel[d] * 16)) : 128'(0);
    endfunction

    function automatic logic exp_ready(int d);
        return !cur_rst[d] && (!m_full[d] || cur_rdy[d][m_sel[d]]);
    endfunction

    task automatic check_all();
        check("dut8_in_ready",  128'(ir0), 128'(exp_ready(0)));
        check("dut8_out_valid", 128'(ov0), exp_valid(0));
        check("dut8_out_data",  128'(od0), exp_data(0));
        check("dut6_in_ready",  128'(ir1), 128'(exp_ready(1)));
        check("dut6_out_valid", 128'(ov1), exp_valid(1));
        check("dut6_out_data",  128'(od1), exp_data(1));
`ifdef DMUX_NWAY_DROP_CNT_EN
        check("dut8_drop_count", 128'(dc0), 128'(m_drops[0]));
        check("dut6_drop_count", 128'(dc1), 128'(m_drops[1]));
`endif
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (cur_rst[d]) begin
                m_full[d]  = 1'b0;
                m_drops[d] = 0;
            end else begin
                bit drained, taken;
                drained = m_full[d] && cur_rdy[d][m_sel[d]];
                taken   = cur_vld[d] && (!m_full[d] || drained);
                if (drained) m_full[d] = 1'b0;
                if (taken) begin
                    if (int'(cur_sel[d]) < nch[d]) begin
                        m_full[d] = 1'b1;
                        m_sel[d]  = int'(cur_sel[d]);
                        m_data[d] = cur_dat[d];
                    end else if (m_drops[d] < 255) begin
                        m_drops[d]++;
                    end
                end
            end
        end
    endtask

    // Entered at a falling edge: drive instance d (the other idles), check, clock, model.
    task automatic step(input int d, input bit rst, input bit vld, input logic [15:0] dat,
                        input logic [2:0] sel, input logic [7:0] rdy);
        cur_rst[d] = rst;
        cur_vld[d] = vld;
        cur_dat[d] = dat;
        cur_sel[d] = sel;
        cur_rdy[d] = rdy;
        cur_rst[1-d] = 1'b0;
        cur_vld[1-d] = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        nch[0] = 8;
        nch[1] = 6;
        for (int d = 0; d < 2; d++) begin
            cur_rst[d] = 1'b1; cur_vld[d] = 1'b0; cur_dat[d] = '0;
            cur_sel[d] = '0;   cur_rdy[d] = '0;
            m_full[d]  = 1'b0; m_sel[d]   = 0;    m_data[d] = '0; m_drops[d] = 0;
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Reset: in_ready low while reset is high, empty afterwards
        cur_rst[1] = 1'b1;
        step(0, 1'b1, 1'b1, 16'hAAAA, 3'd1, 8'hFF);
        check("reset_in_ready_low", 128'(ir0), 128'(0));

        // Single word to channel 5
        step(0, 1'b0, 1'b1, 16'h1234, 3'd5, 8'hFF);
        #1;
        check("req030_valid", 128'(ov0), 128'(8'b0010_0000));
        check("req030_lanes", od0, 128'(16'h1234) << 80);
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);

        // Stall on channel 2 for three cycles, then drain
        step(0, 1'b0, 1'b1, 16'hBEEF, 3'd2, 8'hFB);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 1'b1, 16'h5555, 3'd6, 8'hFB);
        end
        #1;
        check("stall_lane2_held", od0, 128'(16'hBEEF) << 32);
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);

        // Back-to-back streaming across all channels
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 1'b1, 16'(16'hC000 + i), 3'(i), 8'hFF);
        end
        #1;
        check("stream_last_lane7", 128'(ov0), 128'(8'h80));
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);

        // Wrong-channel ready must not drain channel 4
        step(0, 1'b0, 1'b1, 16'h4444, 3'd4, 8'b1110_1111);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 1'b1, 16'h9999, 3'd1, 8'b1110_1111);
        end
        #1;
        check("wrong_ready_held", 128'(ov0), 128'(8'b0001_0000));

        // Reset while full and stalled on channel 3
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
        step(0, 1'b0, 1'b1, 16'h3333, 3'd3, 8'h00);
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00);
        step(0, 1'b1, 1'b0, 16'h0, 3'd0, 8'h00);
        #1;
        check("reset_mid_stall_valid", 128'(ov0), 128'(0));
        check("reset_mid_stall_data", od0, 128'(0));
        step(0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00);

        // Out-of-range selects on the 6-channel instance
        step(1, 1'b0, 1'b1, 16'hDEAD, 3'd7, 8'hFF);
        #1;
        check("oor_no_valid", 128'(ov1), 128'(0));
`ifdef DMUX_NWAY_DROP_CNT_EN
        check("oor_drop_one", 128'(dc1), 128'(1));
`endif
        step(1, 1'b0, 1'b1, 16'hDEAD, 3'd6, 8'hFF);
        for (int i = 0; i < 300; i++) begin
            step(1, 1'b0, 1'b1, 16'(i), 3'(6 + (i % 2)), 8'hFF);
        end
`ifdef DMUX_NWAY_DROP_CNT_EN
        #1;
        check("drop_saturated", 128'(dc1), 128'(255));
`endif
        // Out-of-range accept while a stalled entry drains in the same cycle
        step(1, 1'b0, 1'b1, 16'h0101, 3'd2, 8'h00);
        step(1, 1'b0, 1'b1, 16'h0202, 3'd7, 8'hFF);
        step(1, 1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);

        // Randomised traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            step(int'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
                 8'($urandom | $urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dmux_nway_reg
